// File: rtl/fpaddsub_norm_shifter.sv
// Post-add normalizer for the single-precision add/sub path: handles carry-out with a
// 1-bit right shift and cancellation with an iterative left shift of up to SHIFT_STEP bits/cycle.
module fpaddsub_norm_shifter #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InValid,
  output logic        InReady,
  input  logic        SgnIn,
  input  logic [7:0]  SumE,
  input  logic [26:0] Sum,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Sgn,
  output logic [8:0]  NormE,
  output logic [22:0] NormM,
  output logic        R,
  output logic        S
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [25:0] w_q, w_d;
  logic [8:0]  e_q, e_d;
  logic        sgn_q, sgn_d;
  logic [8:0]  norme_q, norme_d;
  logic [22:0] normm_q, normm_d;
  logic        r_q, r_d;
  logic        s_q, s_d;

  logic [8:0]  eeff;
  logic [8:0]  lzc;
  logic [8:0]  e_lim;
  logic [8:0]  sh;
  logic [25:0] w_sh;
  logic [8:0]  e_sh;

  // Denormal inputs carry exponent field 0 but scale like exponent 1.
  assign eeff = (SumE == 8'd0) ? 9'd1 : {1'b0, SumE};

  // Highest set bit wins since the loop walks upward.
  always_comb begin
    lzc = 9'd26;
    for (int i = 0; i < 26; i++) begin
      if (w_q[i]) lzc = 9'(25 - i);
    end
  end

  assign e_lim = e_q - 9'd1;

  always_comb begin
    sh = 9'(SHIFT_STEP);
    if (lzc < sh) sh = lzc;
    if (e_lim < sh) sh = e_lim;
  end

  assign w_sh = w_q << sh;
  assign e_sh = e_q - sh;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    e_d     = e_q;
    sgn_d   = sgn_q;
    norme_d = norme_q;
    normm_d = normm_q;
    r_d     = r_q;
    s_d     = s_q;
    case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          sgn_d = SgnIn;
          w_d   = Sum[25:0];
          e_d   = eeff;
          if (Sum == 27'd0) begin
            norme_d = 9'd0;
            normm_d = 23'd0;
            r_d     = 1'b0;
            s_d     = 1'b0;
            state_d = ST_DONE;
          end else if (Sum[26]) begin
            norme_d = eeff + 9'd1;
            normm_d = Sum[25:3];
            r_d     = Sum[2];
            s_d     = Sum[1] | Sum[0];
            state_d = ST_DONE;
          end else if (Sum[25]) begin
            norme_d = eeff;
            normm_d = Sum[24:2];
            r_d     = Sum[1];
            s_d     = Sum[0];
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        w_d = w_sh;
        e_d = e_sh;
        // Exit either normalized or pinned at the minimum exponent (denormal result).
        if (w_sh[25] || (e_sh == 9'd1)) begin
          norme_d = w_sh[25] ? e_sh : 9'd0;
          normm_d = w_sh[24:2];
          r_d     = w_sh[1];
          s_d     = w_sh[0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (OutReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      w_q     <= 26'd0;
      e_q     <= 9'd0;
      sgn_q   <= 1'b0;
      norme_q <= 9'd0;
      normm_q <= 23'd0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      e_q     <= e_d;
      sgn_q   <= sgn_d;
      norme_q <= norme_d;
      normm_q <= normm_d;
      r_q     <= r_d;
      s_q     <= s_d;
    end
  end

  assign InReady  = (state_q == ST_IDLE);
  assign OutValid = (state_q == ST_DONE);
  assign Sgn      = sgn_q;
  assign NormE    = norme_q;
  assign NormM    = normm_q;
  assign R        = r_q;
  assign S        = s_q;

endmodule

// File: tb/tb_fpaddsub_norm_shifter.sv
// Scoreboard bench for fpaddsub_norm_shifter: directed cases with hand-derived results
// plus random sums checked against a closed-form normalization model.
module tb_fpaddsub_norm_shifter;
  localparam int STEP = 4;

  logic        CLK = 1'b0;
  logic        RST, InValid, InReady, SgnIn, OutValid, OutReady, Sgn, R, S;
  logic [7:0]  SumE;
  logic [26:0] Sum;
  logic [8:0]  NormE;
  logic [22:0] NormM;

  typedef struct packed {
    logic [7:0]  lat;
    logic        sgn;
    logic [8:0]  e;
    logic [22:0] m;
    logic        r;
    logic        s;
  } res_t;

  res_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fpaddsub_norm_shifter #(.SHIFT_STEP(STEP)) dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady), .SgnIn(SgnIn),
    .SumE(SumE), .Sum(Sum), .OutValid(OutValid), .OutReady(OutReady), .Sgn(Sgn),
    .NormE(NormE), .NormM(NormM), .R(R), .S(S)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Push expectation, present the sum and wait for the accepting edge.
  task automatic send(input logic sg, input logic [7:0] se, input logic [26:0] sm, input res_t exp);
    int n = 0;
    sb.push_back(exp);
    SgnIn = sg; SumE = se; Sum = sm; InValid = 1'b1;
    while (!InReady && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!InReady) begin
      errors++;
      $display("FAIL accept_timeout InReady=%0b required=1", InReady);
    end
    tick();
    InValid = 1'b0;
    SgnIn = $urandom_range(0, 1); SumE = 8'($urandom); Sum = 27'($urandom);
  endtask

  task automatic collect(output res_t obs);
    int lat = 1;
    while (!OutValid && lat < 60) begin
      tick();
      lat++;
    end
    obs = {8'(lat), Sgn, NormE, NormM, R, S};
  endtask

  function automatic res_t model(input logic sg, input logic [7:0] se, input logic [26:0] sm);
    res_t o;
    int e, k, t;
    logic [25:0] w;
    e = (se == 8'd0) ? 1 : int'(se);
    o = '0;
    o.sgn = sg;
    o.lat = 8'd1;
    if (sm == 27'd0) begin
      o.sgn = sg;
    end else if (sm[26]) begin
      o.e = 9'(e + 1); o.m = sm[25:3]; o.r = sm[2]; o.s = sm[1] | sm[0];
    end else if (sm[25]) begin
      o.e = 9'(e); o.m = sm[24:2]; o.r = sm[1]; o.s = sm[0];
    end else begin
      w = sm[25:0];
      k = 0;
      while (!w[25 - k]) k++;
      t = (k < e - 1) ? k : e - 1;
      w = w << t;
      o.e = w[25] ? 9'(e - t) : 9'd0;
      o.m = w[24:2]; o.r = w[1]; o.s = w[0];
      o.lat = 8'(1 + ((t == 0) ? 1 : (t + STEP - 1) / STEP));
    end
    return o;
  endfunction

  task automatic pop_check(input string name, input res_t obs);
    res_t exp;
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got lat=%0d sgn=%0b e=%h m=%h r=%0b s=%0b required lat=%0d sgn=%0b e=%h m=%h r=%0b s=%0b",
               name, obs.lat, obs.sgn, obs.e, obs.m, obs.r, obs.s,
               exp.lat, exp.sgn, exp.e, exp.m, exp.r, exp.s);
    end else begin
      $display("ok %s lat=%0d e=%h m=%h r=%0b s=%0b", name, obs.lat, obs.e, obs.m, obs.r, obs.s);
    end
  endtask

  task automatic release_out();
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; InValid = 1'b0; OutReady = 1'b0; SgnIn = 1'b0; SumE = 8'd0; Sum = 27'd0;
    tick(); tick();
    RST = 1'b0;
    checks++;
    if ({OutValid, Sgn, NormE, NormM, R, S, InReady} !== {1'b0, 1'b0, 9'd0, 23'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset got ov=%0b sgn=%0b e=%h m=%h r=%0b s=%0b ir=%0b required all 0, ir=1",
               OutValid, Sgn, NormE, NormM, R, S, InReady);
    end else $display("ok reset");
  endtask

  task automatic test_carry();
    res_t obs;
    send(1'b0, 8'h80, 27'h4000007, '{8'd1, 1'b0, 9'h081, 23'h0, 1'b1, 1'b1});
    collect(obs); pop_check("carry", obs); release_out();
    send(1'b0, 8'hFF, 27'h4000000, '{8'd1, 1'b0, 9'h100, 23'h0, 1'b0, 1'b0});
    collect(obs); pop_check("carry_overflow", obs); release_out();
  endtask

  task automatic test_cancel();
    res_t obs;
    send(1'b1, 8'h80, 27'h0100002, '{8'd3, 1'b1, 9'h07B, 23'h000010, 1'b0, 1'b0});
    collect(obs); pop_check("cancel", obs); release_out();
  endtask

  task automatic test_denormal();
    res_t obs;
    send(1'b0, 8'h03, 27'h0000100, '{8'd2, 1'b0, 9'h000, 23'h000100, 1'b0, 1'b0});
    collect(obs); pop_check("denormal_clamp", obs); release_out();
    send(1'b1, 8'h00, 27'h0000108, '{8'd2, 1'b1, 9'h000, 23'h000042, 1'b0, 1'b0});
    collect(obs); pop_check("denormal_e1", obs); release_out();
  endtask

  task automatic test_zero_backpressure();
    res_t obs;
    send(1'b0, 8'h55, 27'h0, '{8'd1, 1'b0, 9'h0, 23'h0, 1'b0, 1'b0});
    collect(obs); pop_check("zero", obs);
    InValid = 1'b1; Sum = 27'h4000007; SumE = 8'h10; SgnIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({OutValid, Sgn, NormE, NormM, R, S, InReady} !== {1'b1, 1'b0, 9'd0, 23'd0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d got ov=%0b sgn=%0b e=%h m=%h r=%0b s=%0b ir=%0b required ov=1 zeros ir=0",
                 i, OutValid, Sgn, NormE, NormM, R, S, InReady);
      end else $display("ok hold_%0d", i);
    end
    InValid = 1'b0;
    release_out();
    checks++;
    if ({OutValid, InReady} !== 2'b01) begin
      errors++;
      $display("FAIL zero_release got ov=%0b ir=%0b required ov=0 ir=1", OutValid, InReady);
    end else $display("ok zero_release");
  endtask

  task automatic test_reset_mid_shift();
    res_t obs, dropped;
    send(1'b1, 8'h80, 27'h0100002, '{8'd3, 1'b1, 9'h07B, 23'h000010, 1'b0, 1'b0});
    RST = 1'b1;
    tick();
    RST = 1'b0;
    dropped = sb.pop_back();
    checks++;
    if ({OutValid, Sgn, NormE, NormM, R, S, InReady} !== {1'b0, 1'b0, 9'd0, 23'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_shift got ov=%0b sgn=%0b e=%h m=%h r=%0b s=%0b ir=%0b required all 0, ir=1 (dropped e=%h)",
               OutValid, Sgn, NormE, NormM, R, S, InReady, dropped.e);
    end else $display("ok reset_mid_shift");
    send(1'b1, 8'h10, 27'h2000001, '{8'd1, 1'b1, 9'h010, 23'h0, 1'b0, 1'b1});
    collect(obs); pop_check("after_reset", obs); release_out();
  endtask

  task automatic test_back_to_back();
    res_t obs;
    OutReady = 1'b1;
    send(1'b0, 8'h80, 27'h0100002, model(1'b0, 8'h80, 27'h0100002));
    collect(obs); pop_check("b2b_first", obs);
    tick();
    checks++;
    if ({OutValid, InReady} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_single_transfer got ov=%0b ir=%0b required ov=0 ir=1", OutValid, InReady);
    end else $display("ok b2b_single_transfer");
    send(1'b1, 8'h20, 27'h3FFFFFF, '{8'd1, 1'b1, 9'h020, 23'h7FFFFF, 1'b1, 1'b1});
    collect(obs); pop_check("b2b_second", obs);
    tick();
    OutReady = 1'b0;
  endtask

  task automatic test_random();
    res_t obs;
    logic [26:0] sm;
    logic [7:0]  se;
    logic        sg;
    int lz;
    for (int n = 0; n < 30; n++) begin
      sg = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      case ($urandom_range(0, 4))
        0: sm = 27'd0;
        1: sm = 27'($urandom) | 27'h4000000;
        2: sm = (27'($urandom) & 27'h1FFFFFF) | 27'h2000000;
        default: begin
          lz = $urandom_range(1, 25);
          sm = 27'($urandom) & ((27'h1 << (26 - lz)) - 27'd1);
          sm = sm | (27'h1 << (25 - lz));
        end
      endcase
      send(sg, se, sm, model(sg, se, sm));
      collect(obs);
      pop_check($sformatf("rand_%0d", n), obs);
      repeat ($urandom_range(0, 2)) tick();
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_cancel();
    test_denormal();
    test_reset_mid_shift();
    test_zero_backpressure();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
